// File: rtl/eth_cfg_sequencer_if.sv
// Byte-wide configuration write port from the sequencer to the Ethernet MAC,
// including the RX enable that the sequencer gates around the write burst.
interface eth_cfg_sequencer_if;
    logic       cfg_valid;
    logic [4:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       cfg_enable_rx;

    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_wdata,
        output cfg_enable_rx
    );

    modport slave (
        input cfg_valid,
        input cfg_addr,
        input cfg_wdata,
        input cfg_enable_rx
    );
endinterface

// File: rtl/eth_cfg_sequencer.sv
// Snapshots MAC/IP/UDP settings, holds MAC RX off while draining, streams every
// configuration byte over the cfg port, then hands RX enable back to rx_allow.
module eth_cfg_sequencer #(
    parameter int UDP_N      = 4,
    parameter int DRAIN_CYC  = 64,
    parameter int WR_GAP     = 0,
    parameter bit AUTO_START = 1'b1
) (
    input  logic                cfg_clk,
    input  logic                cfg_rst,
    input  logic                start,
    input  logic [47:0]         mac,
    input  logic [31:0]         ip,
    input  logic [16*UDP_N-1:0] udp_ports,
    input  logic                rx_allow,
    eth_cfg_sequencer_if.master cfg,
    output logic                busy,
    output logic                cfg_done
);
    localparam int TOTAL = 10 + 2 * UDP_N;
    localparam int IW    = $clog2(TOTAL + 1);

    localparam logic [IW-1:0] IP_BASE   = IW'(6);
    localparam logic [IW-1:0] UDP_BASE  = IW'(10);
    localparam logic [IW-1:0] TOTAL_IDX = IW'(TOTAL);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRAIN  = 3'd1;
    localparam logic [2:0] ST_WRITE  = 3'd2;
    localparam logic [2:0] ST_ENABLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // The UDP byte index shares a 4-bit address field, so more than 8 ports cannot be addressed.
    if (UDP_N < 1 || UDP_N > 8 || DRAIN_CYC < 1 || DRAIN_CYC > 255 || WR_GAP < 0 || WR_GAP > 15) begin : g_bad_param
        $error("eth_cfg_sequencer: UDP_N 1..8, DRAIN_CYC 1..255, WR_GAP 0..15");
    end

    logic [2:0]         state_r;
    logic               pending_r;
    logic               auto_r;
    logic [7:0]         drain_cnt_r;
    logic [3:0]         gap_cnt_r;
    logic [IW-1:0]      idx_r;
    logic [47:0]        mac_r;
    logic [31:0]        ip_r;
    logic [16*UDP_N-1:0] udp_r;
    logic               valid_r;
    logic [4:0]         addr_r;
    logic [7:0]         wdata_r;
    logic               en_r;
    logic               busy_r;
    logic               done_r;

    logic [4:0]         wr_addr_s;
    logic [7:0]         wr_data_s;
    logic               trigger_s;
    logic               emit_s;

    // Address and data of the byte at the current list position
    always_comb begin
        wr_addr_s = 5'd0;
        wr_data_s = 8'd0;
        if (idx_r < IP_BASE) begin
            wr_addr_s = 5'(idx_r);
            wr_data_s = 8'(mac_r >> (8 * (5 - int'(idx_r))));
        end else if (idx_r < UDP_BASE) begin
            wr_addr_s = 5'(idx_r);
            wr_data_s = 8'(ip_r >> (8 * (9 - int'(idx_r))));
        end else begin
            // List position 10+2k+h maps to address 16+2k+h; high byte of port k comes first.
            wr_addr_s = 5'(int'(idx_r) + 6);
            wr_data_s = 8'(udp_r >> (8 * ((int'(idx_r) - 10) ^ 1)));
        end
    end

    // Sequence start and write-strobe decisions
    always_comb begin
        trigger_s = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && (start || auto_r || pending_r);
        if (state_r == ST_DRAIN) begin
            emit_s = (drain_cnt_r == 8'(DRAIN_CYC - 1));
        end else if (state_r == ST_WRITE) begin
            emit_s = (idx_r != TOTAL_IDX) && (gap_cnt_r == 4'(WR_GAP));
        end else begin
            emit_s = 1'b0;
        end
    end

    // Sequencer state, configuration snapshot and registered port outputs
    always_ff @(posedge cfg_clk) begin
        if (cfg_rst) begin
            state_r     <= ST_IDLE;
            pending_r   <= 1'b0;
            auto_r      <= AUTO_START;
            drain_cnt_r <= 8'd0;
            gap_cnt_r   <= 4'd0;
            idx_r       <= '0;
            mac_r       <= 48'd0;
            ip_r        <= 32'd0;
            udp_r       <= '0;
            valid_r     <= 1'b0;
            addr_r      <= 5'd0;
            wdata_r     <= 8'd0;
            en_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (start && busy_r) begin
                pending_r <= 1'b1;
            end
            if (emit_s) begin
                valid_r   <= 1'b1;
                addr_r    <= wr_addr_s;
                wdata_r   <= wr_data_s;
                idx_r     <= idx_r + IW'(1);
                gap_cnt_r <= 4'd0;
            end
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (trigger_s) begin
                        state_r     <= ST_DRAIN;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        en_r        <= 1'b0;
                        pending_r   <= 1'b0;
                        auto_r      <= 1'b0;
                        drain_cnt_r <= 8'd0;
                        idx_r       <= '0;
                        mac_r       <= mac;
                        ip_r        <= ip;
                        udp_r       <= udp_ports;
                    end else if (state_r == ST_DONE) begin
                        en_r <= rx_allow;
                    end else begin
                        en_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (emit_s) begin
                        state_r <= ST_WRITE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 8'd1;
                    end
                end
                ST_WRITE: begin
                    if (idx_r == TOTAL_IDX) begin
                        state_r <= ST_ENABLE;
                    end else if (!emit_s) begin
                        gap_cnt_r <= gap_cnt_r + 4'd1;
                    end
                end
                ST_ENABLE: begin
                    state_r <= ST_DONE;
                    // A queued request passes straight through DONE with RX still held off.
                    if (pending_r || start) begin
                        pending_r <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        en_r   <= rx_allow;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    en_r    <= 1'b0;
                end
            endcase
        end
    end

    assign cfg.cfg_valid     = valid_r;
    assign cfg.cfg_addr      = addr_r;
    assign cfg.cfg_wdata     = wdata_r;
    assign cfg.cfg_enable_rx = en_r;
    assign busy              = busy_r;
    assign cfg_done          = done_r;
endmodule

// File: tb/tb_eth_cfg_sequencer.sv
// Directed bench for eth_cfg_sequencer: two instances (WR_GAP 0 and 3) share stimulus,
// a negedge monitor logs strobes and cfg_done edges, checks run at posedge+2.
module tb_eth_cfg_sequencer;
    logic        cfg_clk  = 1'b0;
    logic        cfg_rst  = 1'b1;
    logic        start    = 1'b0;
    logic        rx_allow = 1'b1;
    logic [47:0] mac      = 48'h112233445566;
    logic [31:0] ip       = 32'hC0A80704;
    logic [63:0] ports    = {16'h1F93, 16'h1F92, 16'h1F91, 16'h1F90};
    logic        busy0, done0, busy1, done1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [12:0] q0[$];
    logic [12:0] q1[$];
    int t0q[$];
    int t1q[$];
    int done_rise0 = 0, done_cyc0 = 0, done_rise1 = 0, done_cyc1 = 0, en_nd0 = 0;
    logic done0_p = 1'b0, done1_p = 1'b0;
    logic [12:0] exp1[18];
    logic [12:0] exp2[18];
    int t0, n, base_q, base_d, base_e;

    eth_cfg_sequencer_if if0();
    eth_cfg_sequencer_if if1();

    eth_cfg_sequencer #(.UDP_N(4), .DRAIN_CYC(4), .WR_GAP(0), .AUTO_START(1'b1)) dut0 (
        .cfg_clk(cfg_clk), .cfg_rst(cfg_rst), .start(start), .mac(mac), .ip(ip),
        .udp_ports(ports), .rx_allow(rx_allow), .cfg(if0), .busy(busy0), .cfg_done(done0));

    eth_cfg_sequencer #(.UDP_N(4), .DRAIN_CYC(4), .WR_GAP(3), .AUTO_START(1'b1)) dut1 (
        .cfg_clk(cfg_clk), .cfg_rst(cfg_rst), .start(start), .mac(mac), .ip(ip),
        .udp_ports(ports), .rx_allow(rx_allow), .cfg(if1), .busy(busy1), .cfg_done(done1));

    always #5 cfg_clk = ~cfg_clk;

    always @(posedge cfg_clk) cyc <= cyc + 1;

    always @(negedge cfg_clk) begin
        if (if0.cfg_valid === 1'b1) begin
            q0.push_back({if0.cfg_addr, if0.cfg_wdata});
            t0q.push_back(cyc);
        end
        if (if1.cfg_valid === 1'b1) begin
            q1.push_back({if1.cfg_addr, if1.cfg_wdata});
            t1q.push_back(cyc);
        end
        if (done0 === 1'b1 && done0_p !== 1'b1) begin
            done_rise0 <= done_rise0 + 1;
            done_cyc0  <= cyc;
        end
        if (done1 === 1'b1 && done1_p !== 1'b1) begin
            done_rise1 <= done_rise1 + 1;
            done_cyc1  <= cyc;
        end
        if (if0.cfg_enable_rx === 1'b1 && done0 !== 1'b1) en_nd0 <= en_nd0 + 1;
        done0_p <= done0;
        done1_p <= done1;
    end

    task automatic tick();
        @(posedge cfg_clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    initial begin
        exp1 = '{{5'd0, 8'h11}, {5'd1, 8'h22}, {5'd2, 8'h33}, {5'd3, 8'h44}, {5'd4, 8'h55},
                 {5'd5, 8'h66}, {5'd6, 8'hC0}, {5'd7, 8'hA8}, {5'd8, 8'h07}, {5'd9, 8'h04},
                 {5'd16, 8'h1F}, {5'd17, 8'h90}, {5'd18, 8'h1F}, {5'd19, 8'h91},
                 {5'd20, 8'h1F}, {5'd21, 8'h92}, {5'd22, 8'h1F}, {5'd23, 8'h93}};
        exp2 = exp1;
        exp2[0] = {5'd0, 8'hAA};
        exp2[1] = {5'd1, 8'hBB};
        exp2[2] = {5'd2, 8'hCC};
        exp2[3] = {5'd3, 8'hDD};
        exp2[4] = {5'd4, 8'hEE};
        exp2[5] = {5'd5, 8'hFF};

        // Reset values
        repeat (3) tick();
        chk("rst_valid", if0.cfg_valid, 1'b0);
        chk("rst_addr", if0.cfg_addr, 5'd0);
        chk("rst_wdata", if0.cfg_wdata, 8'd0);
        chk("rst_en_rx", if0.cfg_enable_rx, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_valid_gap3", if1.cfg_valid, 1'b0);

        // Auto start on the first cycle after release
        cfg_rst = 1'b0;
        tick();
        t0 = cyc;
        chk("auto_busy", busy0, 1'b1);
        chk("auto_done", done0, 1'b0);
        chk("auto_en_rx", if0.cfg_enable_rx, 1'b0);

        // MAC changes mid-write; the running sequence keeps its snapshot
        while (cyc < t0 + 8) tick();
        mac = 48'hAABBCCDDEEFF;
        for (int i = 0; i < 200 && done_rise1 == 0; i++) tick();
        chk("run1_gap3_done_seen", done_rise1, 1);
        chk("run1_count", q0.size(), 18);
        for (int i = 0; i < 18 && i < q0.size(); i++) chk("run1_byte", q0[i], exp1[i]);
        if (q0.size() == 18) begin
            chk("run1_first_cyc", t0q[0], t0 + 4);
            chk("run1_last_cyc", t0q[17], t0 + 21);
        end
        chk("run1_done_cyc", done_cyc0, t0 + 23);
        chk("run1_done_rises", done_rise0, 1);
        chk("run1_en_rx", if0.cfg_enable_rx, 1'b1);
        chk("run1_busy", busy0, 1'b0);
        chk("gap3_count", q1.size(), 18);
        for (int i = 0; i < 18 && i < q1.size(); i++) chk("gap3_byte", q1[i], exp1[i]);
        if (q1.size() == 18) begin
            chk("gap3_first_cyc", t1q[0], t0 + 4);
            for (int i = 1; i < 18; i++) chk("gap3_spacing", t1q[i] - t1q[i-1], 4);
            chk("gap3_done_cyc", done_cyc1, t1q[17] + 2);
        end

        // RX follows rx_allow with one cycle of lag while in DONE
        n = q0.size();
        rx_allow = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            chk("rxgate_en_rx", if0.cfg_enable_rx, (i <= 10) ? 1'b0 : 1'b1);
            if (i == 10) rx_allow = 1'b1;
        end
        chk("rxgate_no_strobe", q0.size(), n);
        chk("rxgate_done_held", done0, 1'b1);

        // New start plus repeated starts during DRAIN: exactly one back-to-back rerun
        base_q = q0.size();
        base_d = done_rise0;
        base_e = en_nd0;
        start = 1'b1;
        tick();
        t0 = cyc;
        repeat (3) tick();
        start = 1'b0;
        for (int i = 0; i < 300 && done_rise0 == base_d; i++) tick();
        repeat (3) tick();
        chk("rerun_count", q0.size() - base_q, 36);
        for (int i = 0; i < 36 && base_q + i < q0.size(); i++) chk("rerun_byte", q0[base_q + i], exp2[i % 18]);
        if (q0.size() - base_q == 36) begin
            chk("rerun_first_cyc", t0q[base_q], t0 + 4);
            chk("rerun_second_first_cyc", t0q[base_q + 18], t0 + 28);
            chk("rerun_second_last_cyc", t0q[base_q + 35], t0 + 45);
        end
        chk("rerun_done_cyc", done_cyc0, t0 + 47);
        chk("rerun_done_rises", done_rise0 - base_d, 1);
        chk("rerun_rx_held_off", en_nd0 - base_e, 0);

        // Reset right after the 5th strobe aborts the run
        base_q = q0.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 60 && n < 5; i++) begin
            tick();
            if (if0.cfg_valid === 1'b1) n++;
        end
        chk("abort_5th_seen", n, 5);
        cfg_rst = 1'b1;
        tick();
        chk("abort_valid", if0.cfg_valid, 1'b0);
        chk("abort_addr", if0.cfg_addr, 5'd0);
        chk("abort_wdata", if0.cfg_wdata, 8'd0);
        chk("abort_en_rx", if0.cfg_enable_rx, 1'b0);
        chk("abort_busy", busy0, 1'b0);
        chk("abort_done", done0, 1'b0);
        repeat (4) tick();
        chk("abort_strobes", q0.size() - base_q, 5);
        cfg_rst = 1'b0;
        base_d = done_rise0;
        for (int i = 0; i < 100 && done_rise0 == base_d; i++) tick();
        chk("restart_count", q0.size() - base_q, 23);
        for (int i = 0; i < 18 && base_q + 5 + i < q0.size(); i++) chk("restart_byte", q0[base_q + 5 + i], exp2[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
